// File: rtl/jt51_timer_ctrl.sv
// ----------------------------------------------------------------------------
// jt51_timer_ctrl
// CPU-side register front end for the JT51 timer pair.
//  - Decodes YM2151 bus writes (a0=0 address port, a0=1 data port).
//  - Holds timer A/B preload values, run/load levels and IRQ enables.
//  - Produces one-clk flag-clear pulses and a one-clk up_wr per data write.
//  - Keeps a busy counter (ticks on cen) after every data write.
//  - Returns status {busy,5'b0,flag_B,flag_A} on dout every clk.
// Optional feature macro: JT51_CSM_EN
//  When defined, bit 7 of register 0x14 arms CSM and csm_kon pulses once on
//  every rising edge of (overflow_A & csm). When undefined, csm_kon is 0.
// ----------------------------------------------------------------------------
module jt51_timer_ctrl #(
    parameter int BUSY_CYCLES = 32,
    parameter int BUSY_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        cs_n,
    input  logic        wr_n,
    input  logic        a0,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        flag_A,
    input  logic        flag_B,
    input  logic        overflow_A,
    output logic [9:0]  value_A,
    output logic [7:0]  value_B,
    output logic        load_A,
    output logic        load_B,
    output logic        clr_flag_A,
    output logic        clr_flag_B,
    output logic        enable_irq_A,
    output logic        enable_irq_B,
    output logic [7:0]  up_addr,
    output logic [7:0]  up_data,
    output logic        up_wr,
    output logic        csm_kon
);

    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);
    localparam logic [BUSY_W-1:0] BUSY_ONE  = {{(BUSY_W-1){1'b0}}, 1'b1};
    localparam logic [BUSY_W-1:0] BUSY_ZERO = {BUSY_W{1'b0}};

    logic              we_s;
    logic              we_r;
    logic              we_dly_r;
    logic              a0_r;
    logic [7:0]        din_r;
    logic              wr_edge_s;
    logic              addr_wr_s;
    logic              data_wr_s;
    logic [BUSY_W-1:0] busy_cnt_r;
    logic              busy_s;

`ifdef JT51_CSM_EN
    logic              csm_r;
    logic              csm_last_r;
    logic              csm_trig_s;
`else
    logic              unused_csm_s;
`endif

    assign we_s = ~cs_n & ~wr_n;

    // Strobe edge detection and address/data-port qualification
    always_comb begin
        wr_edge_s = we_r & ~we_dly_r;
        addr_wr_s = 1'b0;
        data_wr_s = 1'b0;
        if (wr_edge_s) begin
            addr_wr_s = ~a0_r;
            data_wr_s = a0_r;
        end else begin
            addr_wr_s = 1'b0;
            data_wr_s = 1'b0;
        end
    end

    // Register the bus strobe together with the port select and data it carried
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r     <= 1'b0;
            we_dly_r <= 1'b0;
            a0_r     <= 1'b0;
            din_r    <= 8'h00;
        end else begin
            we_r     <= we_s;
            we_dly_r <= we_r;
            a0_r     <= a0;
            din_r    <= din;
        end
    end

    // Address latch, data forwarding and timer register decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_addr      <= 8'h00;
            up_data      <= 8'h00;
            up_wr        <= 1'b0;
            value_A      <= 10'h000;
            value_B      <= 8'h00;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
`ifdef JT51_CSM_EN
            csm_r        <= 1'b0;
`endif
        end else begin
            // pulses last exactly one clk unless re-fired below
            up_wr      <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (addr_wr_s) begin
                up_addr <= din_r;
            end else if (data_wr_s) begin
                up_data <= din_r;
                up_wr   <= 1'b1;
                // decode uses the address latched by an earlier address write
                case (up_addr)
                    8'h10: value_A[9:2] <= din_r;
                    8'h11: value_A[1:0] <= din_r[1:0];
                    8'h12: value_B      <= din_r;
                    8'h14: begin
                        load_A       <= din_r[0];
                        load_B       <= din_r[1];
                        enable_irq_A <= din_r[2];
                        enable_irq_B <= din_r[3];
                        clr_flag_A   <= din_r[4];
                        clr_flag_B   <= din_r[5];
`ifdef JT51_CSM_EN
                        csm_r        <= din_r[7];
`endif
                    end
                    default: begin
                        // other registers belong to the rest of the core
                    end
                endcase
            end
        end
    end

    // Busy counter: reload on every data write (retrigger), count down on cen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt_r <= BUSY_ZERO;
        end else if (data_wr_s) begin
            busy_cnt_r <= BUSY_LOAD;
        end else if (cen && (busy_cnt_r != BUSY_ZERO)) begin
            busy_cnt_r <= busy_cnt_r - BUSY_ONE;
        end
    end

    assign busy_s = (busy_cnt_r != BUSY_ZERO);

    // Status read port, refreshed every clk regardless of chip select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 8'h00;
        end else begin
            dout <= {busy_s, 5'b00000, flag_B, flag_A};
        end
    end

`ifdef JT51_CSM_EN
    assign csm_trig_s = overflow_A & csm_r;

    // CSM key-on: one pulse per rising edge of the armed overflow level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csm_last_r <= 1'b0;
            csm_kon    <= 1'b0;
        end else begin
            csm_last_r <= csm_trig_s;
            csm_kon    <= csm_trig_s & ~csm_last_r;
        end
    end
`else
    // overflow_A has no consumer when CSM is compiled out
    assign unused_csm_s = overflow_A;

    // CSM compiled out: key-on output held low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csm_kon <= 1'b0;
        end else begin
            csm_kon <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jt51_timer_ctrl
// Directed bench for jt51_timer_ctrl. Each data-port write pushes its
// hand-computed expected register image into a scoreboard queue; a monitor
// pops and compares whenever the DUT pulses up_wr. Status, busy timing, CSM
// and reset behaviour are checked directly from the stimulus process.
// ----------------------------------------------------------------------------
module tb_jt51_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A;
    logic       load_B;
    logic       clr_flag_A;
    logic       clr_flag_B;
    logic       enable_irq_A;
    logic       enable_irq_B;
    logic [7:0] up_addr;
    logic [7:0] up_data;
    logic       up_wr;
    logic       csm_kon;

    logic       set_A;
    logic       set_B;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic [9:0] va;
        logic [7:0] vb;
        logic [3:0] ctl;   // {irqB, irqA, loadB, loadA}
        logic [1:0] clr;   // {clrB, clrA}
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_upwr   = 0;
    int n_kon    = 0;

    jt51_timer_ctrl #(.BUSY_CYCLES(32), .BUSY_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .cs_n         (cs_n),
        .wr_n         (wr_n),
        .a0           (a0),
        .din          (din),
        .dout         (dout),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .overflow_A   (overflow_A),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .up_addr      (up_addr),
        .up_data      (up_data),
        .up_wr        (up_wr),
        .csm_kon      (csm_kon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer-side flag model: set on request, cleared by the DUT's clear pulse
    always @(posedge clk) begin
        if (clr_flag_A) flag_A <= 1'b0;
        else if (set_A) flag_A <= 1'b1;
        if (clr_flag_B) flag_B <= 1'b0;
        else if (set_B) flag_B <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (up_wr) begin
                n_upwr++;
                if (sb.size() == 0) begin
                    check("unexpected_up_wr", {24'd0, up_data}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("up_addr", {24'd0, up_addr}, {24'd0, mon_e.addr});
                    check("up_data", {24'd0, up_data}, {24'd0, mon_e.data});
                    check("value_A", {22'd0, value_A}, {22'd0, mon_e.va});
                    check("value_B", {24'd0, value_B}, {24'd0, mon_e.vb});
                    check("ctl", {28'd0, enable_irq_B, enable_irq_A, load_B, load_A},
                          {28'd0, mon_e.ctl});
                    check("clr_pulse", {30'd0, clr_flag_B, clr_flag_A}, {30'd0, mon_e.clr});
                end
            end else begin
                check("clr_without_up_wr", {30'd0, clr_flag_B, clr_flag_A}, 32'd0);
            end
            if (csm_kon) n_kon++;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(posedge clk); #1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(posedge clk); #1;
        cs_n = 1'b1; wr_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic data_write(input logic [7:0] d, input logic [7:0] ea, input logic [9:0] eva,
                              input logic [7:0] evb, input logic [3:0] ectl, input logic [1:0] eclr);
        exp_t e;
        e.addr = ea; e.data = d; e.va = eva; e.vb = evb; e.ctl = ectl; e.clr = eclr;
        sb.push_back(e);
        n_pushed++;
        bus_write(1'b1, d);
    endtask

    // caller sits on a posedge; leaves cen high for n edges
    task automatic run_cen(input int n);
        #1 cen = 1'b1;
        repeat (n) @(posedge clk);
        #1 cen = 1'b0;
    endtask

    task automatic check_busy(input string name, input logic expb);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(name, {31'd0, dout[7]}, {31'd0, expb});
        @(posedge clk);
    endtask

    int kon_before;
    logic exp_kon;

    initial begin
        rst = 1'b1; cen = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
        overflow_A = 1'b0; set_A = 1'b0; set_B = 1'b0; flag_A = 1'b0; flag_B = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_value_A", {22'd0, value_A}, 32'h000);
        check("rst_value_B", {24'd0, value_B}, 32'h00);
        check("rst_ctl", {28'd0, enable_irq_B, enable_irq_A, load_B, load_A}, 32'd0);
        check("rst_pulses", {29'd0, up_wr, csm_kon, clr_flag_A | clr_flag_B}, 32'd0);
        check("rst_up_addr", {24'd0, up_addr}, 32'h00);

        // Timer A preload split across two registers
        bus_write(1'b0, 8'h10);
        data_write(8'hA5, 8'h10, 10'h294, 8'h00, 4'b0000, 2'b00);
        bus_write(1'b0, 8'h11);
        data_write(8'h03, 8'h11, 10'h297, 8'h00, 4'b0000, 2'b00);
        check_busy("busy_after_write", 1'b1);
        run_cen(31);
        check_busy("busy_at_count_1", 1'b1);
        run_cen(1);
        check_busy("busy_expired", 1'b0);

        // Address write alone leaves busy clear
        bus_write(1'b0, 8'h12);
        check_busy("addr_write_no_busy", 1'b0);
        data_write(8'h5C, 8'h12, 10'h297, 8'h5C, 4'b0000, 2'b00);

        // Flags reported then cleared by register 0x14
        @(posedge clk); #1 set_A = 1'b1; set_B = 1'b1;
        @(posedge clk); #1 set_A = 1'b0; set_B = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("flags_set", {30'd0, dout[1:0]}, 32'd3);
        bus_write(1'b0, 8'h14);
        data_write(8'h35, 8'h14, 10'h297, 8'h5C, 4'b0101, 2'b11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flags_cleared", {30'd0, dout[1:0]}, 32'd0);
        check("load_A_level", {31'd0, load_A}, 32'd1);

        // Busy retrigger at count 5 (counter was reloaded by the 0x35 write)
        @(posedge clk);
        run_cen(27);
        bus_write(1'b0, 8'h20);
        data_write(8'h77, 8'h20, 10'h297, 8'h5C, 4'b0101, 2'b00);
        run_cen(31);
        check_busy("busy_retrigger_held", 1'b1);
        run_cen(1);
        check_busy("busy_retrigger_expired", 1'b0);

        // CSM key-on
        bus_write(1'b0, 8'h14);
        data_write(8'h81, 8'h14, 10'h297, 8'h5C, 4'b0001, 2'b00);
        kon_before = n_kon;
        @(posedge clk); #1 overflow_A = 1'b1;
        repeat (3) @(posedge clk);
        #1 overflow_A = 1'b0;
        repeat (4) @(posedge clk);
`ifdef JT51_CSM_EN
        exp_kon = 1'b1;
`else
        exp_kon = 1'b0;
`endif
        check("csm_kon_count", n_kon - kon_before, {31'd0, exp_kon});

        // Strobe held low for 10 clks -> a single data write
        bus_write(1'b0, 8'h30);
        sb.push_back('{addr: 8'h30, data: 8'h42, va: 10'h297, vb: 8'h5C, ctl: 4'b0001, clr: 2'b00});
        n_pushed++;
        @(posedge clk); #1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h42;
        repeat (10) @(posedge clk);
        #1 cs_n = 1'b1; wr_n = 1'b1;
        repeat (4) @(posedge clk);
        check("held_strobe_queue_drained", sb.size(), 32'd0);
        check("up_wr_total", n_upwr, n_pushed);

        // Reset in the middle of a busy period
        @(negedge clk);
        check("busy_before_rst", {31'd0, dout[7]}, 32'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy_dout", {24'd0, dout}, 32'h00);
        check("rst_mid_value_A", {22'd0, value_A}, 32'h000);
        check("rst_mid_up_addr", {24'd0, up_addr}, 32'h00);
        check("rst_mid_ctl", {28'd0, enable_irq_B, enable_irq_A, load_B, load_A}, 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_after_rst_release", {31'd0, dout[7]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
